// File: rtl/demux_dist.sv
// demux_dist: 1-to-31 write-side distributor.
// One DW-bit input stream is steered by a 5-bit select into 31 holding registers,
// each with its own valid/ack handshake. Select code 31 accepts and discards the
// word, strobing drop_pulse and bumping a saturating drop counter.
module demux_dist #(
    parameter int unsigned LANES = 31,
    parameter int unsigned DW    = 2,
    parameter int unsigned CW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_sel,
    input  logic [DW-1:0]       in_data,
    output logic [LANES*DW-1:0] out_data,
    output logic [LANES-1:0]    out_valid,
    input  logic [LANES-1:0]    out_ack,
    output logic                drop_pulse,
    output logic [CW-1:0]       drop_count,
    output logic [4:0]          busy_count
);

    localparam logic [4:0]    DROP_SEL = 5'd31;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic [LANES-1:0]    valid_q;
    logic [LANES-1:0]    valid_d;
    logic [LANES-1:0]    lane_wr;
    logic [LANES*DW-1:0] data_q;
    logic                drop_q;
    logic [CW-1:0]       drop_cnt_q;
    logic                sel_ready;
    logic                accept;
    logic                accept_drop;
    logic [4:0]          busy;

    // Ready decode: the drop code never matches a lane, so it stays ready.
    // An ack on the target lane frees it this cycle (pass-through, no bubble).
    always_comb begin
        sel_ready = 1'b1;
        for (int k = 0; k < int'(LANES); k++) begin
            if (in_sel == 5'(k)) begin
                sel_ready = ~valid_q[k] | out_ack[k];
            end
        end
    end

    assign in_ready    = sel_ready;
    // Gating by in_valid keeps an unknown select from touching state when idle.
    assign accept      = in_valid & sel_ready;
    assign accept_drop = accept & (in_sel == DROP_SEL);

    // Per-lane write strobes and next valid: a write wins over a same-cycle ack.
    always_comb begin
        lane_wr = '0;
        valid_d = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane_wr[k] = accept & (in_sel == 5'(k));
            valid_d[k] = lane_wr[k] | (valid_q[k] & ~out_ack[k]);
        end
    end

    // Lane valid flags and held data; data is retained (not cleared) after ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < int'(LANES); k++) begin
                if (lane_wr[k]) begin
                    data_q[k*DW +: DW] <= in_data;
                end
            end
        end
    end

    // Drop strobe and saturating drop counter, both updated on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_q <= accept_drop;
            if (accept_drop && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_q <= drop_cnt_q + CW'(1);
            end
        end
    end

    // Occupancy: population count of the registered valid vector.
    always_comb begin
        busy = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            busy = busy + 5'(valid_q[k]);
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign drop_pulse = drop_q;
    assign drop_count = drop_cnt_q;
    assign busy_count = busy;

endmodule
